// File: rtl/draw_box.sv
// Draw stage of the star finder: expands a bounding box by one pixel, clamps it to the
// image and raster-scans it, plotting the outline (or the whole box with DRAW_BOX_FILL_EN).
module draw_box #(
    parameter int unsigned      XSZ        = 3,
    parameter int unsigned      YSZ        = 3,
    parameter int unsigned      COLSZ      = 3,
    parameter int unsigned      MAX_X      = 6,
    parameter int unsigned      MAX_Y      = 6,
    parameter logic [COLSZ-1:0] BOX_COLOUR = 3'b100
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             goDraw,
    input  logic [YSZ-1:0]   top,
    input  logic [YSZ-1:0]   bottom,
    input  logic [XSZ-1:0]   left,
    input  logic [XSZ-1:0]   right,
    output logic [XSZ-1:0]   x,
    output logic [YSZ-1:0]   y,
    output logic [COLSZ-1:0] colour,
    output logic             plot,
    output logic             doneDraw
);

    localparam int unsigned XW = XSZ + 1;
    localparam int unsigned YW = YSZ + 1;
    localparam logic [XW-1:0] MAXXW = XW'(MAX_X);
    localparam logic [YW-1:0] MAXYW = YW'(MAX_Y);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, nextState;

    logic [XSZ-1:0]   boxL, boxR, nextL, nextR, nextX;
    logic [YSZ-1:0]   boxT, boxB, nextT, nextB, nextY;
    logic             plotD, doneD;
    logic [COLSZ-1:0] colourD;

    // Expanded box computed one bit wider so the +1/-1 never wraps
    logic [XW-1:0] leftW, rightW, expL, expR;
    logic [YW-1:0] topW, bottomW, expT, expB;
    logic          boxValid;

    always_comb begin
        leftW   = {1'b0, left};
        rightW  = {1'b0, right};
        topW    = {1'b0, top};
        bottomW = {1'b0, bottom};
        expL    = (leftW == '0) ? '0 : leftW - XW'(1);
        expR    = (rightW == MAXXW - XW'(1)) ? rightW : rightW + XW'(1);
        expT    = (topW == '0) ? '0 : topW - YW'(1);
        expB    = (bottomW == MAXYW - YW'(1)) ? bottomW : bottomW + YW'(1);
        boxValid = (topW <= bottomW) && (leftW <= rightW) &&
                   (topW < MAXYW) && (bottomW < MAXYW) &&
                   (leftW < MAXXW) && (rightW < MAXXW);
    end

    // Next-state, next counters and the registered plot/done decode
    always_comb begin
        nextState = state;
        nextX     = x;
        nextY     = y;
        nextL     = boxL;
        nextR     = boxR;
        nextT     = boxT;
        nextB     = boxB;
        plotD     = 1'b0;
        doneD     = 1'b0;
        colourD   = '0;

        case (state)
            IDLE: begin
                if (goDraw) nextState = LOAD;
            end
            LOAD: begin
                nextL     = XSZ'(expL);
                nextR     = XSZ'(expR);
                nextT     = YSZ'(expT);
                nextB     = YSZ'(expB);
                nextX     = nextL;
                nextY     = nextT;
                nextState = boxValid ? SCAN : DONE;
            end
            SCAN: begin
                if (!goDraw) begin
                    nextState = IDLE;
                end else if (x == boxR && y == boxB) begin
                    nextState = DONE;
                end else if (x == boxR) begin
                    nextX = boxL;
                    nextY = y + YSZ'(1);
                end else begin
                    nextX = x + XSZ'(1);
                end
            end
            DONE: begin
                if (!goDraw) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase

        doneD = (nextState == DONE);
`ifdef DRAW_BOX_FILL_EN
        plotD = (nextState == SCAN);
`else
        plotD = (nextState == SCAN) &&
                (nextX == nextL || nextX == nextR || nextY == nextT || nextY == nextB);
`endif
        colourD = plotD ? BOX_COLOUR : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            boxL     <= '0;
            boxR     <= '0;
            boxT     <= '0;
            boxB     <= '0;
            plot     <= 1'b0;
            colour   <= '0;
            doneDraw <= 1'b0;
        end else begin
            state    <= nextState;
            x        <= nextX;
            y        <= nextY;
            boxL     <= nextL;
            boxR     <= nextR;
            boxT     <= nextT;
            boxB     <= nextB;
            plot     <= plotD;
            colour   <= colourD;
            doneDraw <= doneD;
        end
    end

endmodule

// File: tb/tb_draw_box.sv
// Scoreboard bench for draw_box: stimulus queues expected plots, a negedge monitor checks them.
module tb_draw_box;

    logic       clk = 1'b0;
    logic       resetn;
    logic       goDraw;
    logic [2:0] top, bottom, left, right;
    logic [2:0] x, y, colour;
    logic       plot, doneDraw;

    typedef struct {
        int px;
        int py;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    draw_box dut (
        .clk(clk), .resetn(resetn), .goDraw(goDraw),
        .top(top), .bottom(bottom), .left(left), .right(right),
        .x(x), .y(y), .colour(colour), .plot(plot), .doneDraw(doneDraw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle count %0d)", name, act, expv, cyc);
        end
    endtask

    // Expected raster of the expanded box; pixel i appears at cycle i+2 after the start edge
    task automatic pushBox(input int eL, input int eR, input int eT, input int eB, input int n0);
        int i = 0;
        bit onEdge;
        for (int py = eT; py <= eB; py++) begin
            for (int px = eL; px <= eR; px++) begin
                onEdge = (px == eL) || (px == eR) || (py == eT) || (py == eB);
`ifdef DRAW_BOX_FILL_EN
                onEdge = 1'b1;
`endif
                if (onEdge) sb.push_back('{px, py, n0 + 2 + i});
                i++;
            end
        end
    endtask

    task automatic startDraw(input logic [2:0] t, input logic [2:0] b,
                             input logic [2:0] l, input logic [2:0] r, output int n0);
        @(negedge clk); #1;
        top = t; bottom = b; left = l; right = r;
        goDraw = 1'b1;
        n0 = cyc;
    endtask

    task automatic waitDone(input int n0, input int expCyc, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (doneDraw) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen ? cyc - n0 : -1, expCyc);
    endtask

    task automatic endDraw(input string name);
        goDraw = 1'b0;
        @(negedge clk); #1;
        check({name, " doneDraw fall"}, int'(doneDraw), 0);
        check({name, " pending plots"}, sb.size(), 0);
    endtask

    // Monitor: every plot must match the head of the scoreboard, idle colour must be 0
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (plot === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected plot", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("plot x", int'(x), e.px);
                    check("plot y", int'(y), e.py);
                    check("plot colour", int'(colour), 4);
                    check("plot cycle", cyc, e.cyc);
                end
            end else begin
                check("idle colour", int'(colour), 0);
            end
        end
    end

    initial begin
        int n0;
        resetn = 1'b0;
        goDraw = 1'b0;
        top = '0; bottom = '0; left = '0; right = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset x", int'(x), 0);
        check("reset y", int'(y), 0);
        check("reset plot", int'(plot), 0);
        check("reset colour", int'(colour), 0);
        check("reset doneDraw", int'(doneDraw), 0);
        resetn = 1'b1;

        // Interior box; inputs changed mid-scan must be ignored
        startDraw(3'd2, 3'd3, 3'd2, 3'd3, n0);
        pushBox(1, 4, 1, 4, n0);
        repeat (2) @(negedge clk);
        #1;
        top = 3'd0; bottom = 3'd0; left = 3'd0; right = 3'd0;
        waitDone(n0, 18, "interior done");
        endDraw("interior");

        startDraw(3'd0, 3'd0, 3'd0, 3'd0, n0);
        pushBox(0, 1, 0, 1, n0);
        waitDone(n0, 6, "origin done");
        endDraw("origin");

        startDraw(3'd5, 3'd5, 3'd5, 3'd5, n0);
        pushBox(4, 5, 4, 5, n0);
        waitDone(n0, 6, "far corner done");
        endDraw("far corner");

        // Invalid box: no plots, no restart while goDraw stays high
        startDraw(3'd4, 3'd2, 3'd2, 3'd3, n0);
        waitDone(n0, 2, "invalid done");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            check("invalid doneDraw held", int'(doneDraw), 1);
        end
        endDraw("invalid");

        // Reset in the middle of a scan, then a full rescan
        startDraw(3'd2, 3'd3, 3'd2, 3'd3, n0);
        pushBox(1, 4, 1, 4, n0);
        while (cyc - n0 < 5) begin
            @(negedge clk); #1;
        end
        resetn = 1'b0;
        sb.delete();
        #1;
        check("midscan reset plot", int'(plot), 0);
        check("midscan reset doneDraw", int'(doneDraw), 0);
        check("midscan reset colour", int'(colour), 0);
        check("midscan reset x", int'(x), 0);
        check("midscan reset y", int'(y), 0);
        @(negedge clk); #1;
        resetn = 1'b1;
        n0 = cyc;
        pushBox(1, 4, 1, 4, n0);
        waitDone(n0, 18, "rescan done");
        endDraw("rescan");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
